// File: rtl/prog_loader.sv
// Serial program loader: receives a framed image over 8N1 UART, writes it into
// the program RAM and holds the CPU in reset until the checksum verifies.
module prog_loader #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       cpu_reset,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // Receiver states
    // RX_IDLE  | waiting for a falling edge on the synchronized line
    // RX_START | counting to the start-bit mid-sample
    // RX_DATA  | sampling data bits LSB first
    // RX_STOP  | sampling the stop bit
    // Loader states
    // LD_IDLE  | waiting for the 0xA5 sync byte
    // LD_LEN   | waiting for the length byte
    // LD_DATA  | writing data bytes to program RAM
    // LD_CSUM  | waiting for the checksum byte
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] LD_IDLE = 2'd0;
    localparam logic [1:0] LD_LEN  = 2'd1;
    localparam logic [1:0] LD_DATA = 2'd2;
    localparam logic [1:0] LD_CSUM = 2'd3;

    logic          rx_s1, rx_s2, rx_prev;
    logic [1:0]    rx_state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          byte_valid;
    logic          frame_err;

    logic [1:0]    ld_state;
    logic [8:0]    len_n;
    logic [8:0]    addr;
    logic [7:0]    sum;

    // bit_cnt is a down-counter; each sample is taken on its terminal count
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        bit_cnt  <= HALF_M1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_cnt == '0) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            bit_cnt  <= BIT_M1;
                            bit_idx  <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == '0) begin
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_cnt <= BIT_M1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                default: begin
                    if (bit_cnt == '0) begin
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    // shreg is stable while byte_valid is high; it only shifts after a new start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state  <= LD_IDLE;
            len_n     <= '0;
            addr      <= '0;
            sum       <= '0;
            cpu_reset <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (frame_err && ld_state != LD_IDLE) begin
                error    <= 1'b1;
                ld_state <= LD_IDLE;
            end else if (byte_valid) begin
                case (ld_state)
                    LD_IDLE: begin
                        if (shreg == 8'hA5) begin
                            cpu_reset <= 1'b1;
                            ld_state  <= LD_LEN;
                        end
                    end
                    LD_LEN: begin
                        len_n    <= (shreg == 8'h00) ? 9'd256 : {1'b0, shreg};
                        sum      <= shreg;
                        addr     <= '0;
                        ld_state <= LD_DATA;
                    end
                    LD_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr[7:0];
                        mem_wdata <= shreg;
                        sum       <= sum + shreg;
                        addr      <= addr + 9'd1;
                        if (addr + 9'd1 == len_n) begin
                            ld_state <= LD_CSUM;
                        end
                    end
                    default: begin
                        ld_state <= LD_IDLE;
                        if (shreg == sum) begin
                            done      <= 1'b1;
                            error     <= 1'b0;
                            cpu_reset <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign busy = (ld_state != LD_IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of framed images plus hand-written
// sequences for framing errors, a 256-byte image, rx glitches and mid-frame reset.
module tb_prog_loader;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       cpu_reset, mem_we, busy, done, error;
    logic [7:0] mem_addr, mem_wdata;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] wr_addr [0:1023];
    logic [7:0] wr_data [0:1023];
    int         wr_cnt = 0;
    int         done_cnt = 0;
    logic       we_prev = 1'b0;

    typedef struct {
        string       name;
        int          nb;
        logic [63:0] bytes;
        int          exp_wr;
        int          exp_done;
        logic        exp_err;
        logic        exp_cpu;
    } vec_t;

    vec_t vecs [4];

    prog_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .cpu_reset(cpu_reset), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Write log and done/cpu_reset coincidence, sampled on the falling edge
    always @(negedge clk) begin
        if (mem_we) begin
            chk("mem_we_single_cycle", int'(we_prev), 0);
            wr_addr[wr_cnt % 1024] = mem_addr;
            wr_data[wr_cnt % 1024] = mem_wdata;
            wr_cnt++;
        end
        we_prev = mem_we;
        if (done) begin
            done_cnt++;
            chk("cpu_reset_low_with_done", int'(cpu_reset), 0);
            chk("busy_low_with_done", int'(busy), 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    function automatic logic [7:0] vbyte(input vec_t v, input int i);
        logic [63:0] t;
        t = v.bytes >> (8 * (v.nb - 1 - i));
        return t[7:0];
    endfunction

    task automatic run_vec(input vec_t v);
        int wr_base, done_base;
        wr_base = wr_cnt;
        done_base = done_cnt;
        for (int i = 0; i < v.nb; i++) send_byte(vbyte(v, i), 1'b1);
        repeat (8) tick();
        chk({v.name, "_writes"}, wr_cnt - wr_base, v.exp_wr);
        for (int k = 0; k < v.exp_wr && k < wr_cnt - wr_base; k++) begin
            chk({v.name, "_addr"}, int'(wr_addr[(wr_base + k) % 1024]), k);
            chk({v.name, "_data"}, int'(wr_data[(wr_base + k) % 1024]), int'(vbyte(v, 2 + k)));
        end
        chk({v.name, "_done"}, done_cnt - done_base, v.exp_done);
        chk({v.name, "_error"}, int'(error), int'(v.exp_err));
        chk({v.name, "_cpu_reset"}, int'(cpu_reset), int'(v.exp_cpu));
        chk({v.name, "_busy"}, int'(busy), 0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_cpu_reset"}, int'(cpu_reset), 0);
        chk({name, "_mem_we"}, int'(mem_we), 0);
        chk({name, "_mem_addr"}, int'(mem_addr), 0);
        chk({name, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_error"}, int'(error), 0);
    endtask

    initial begin
        vec_t v;
        int wr_base, done_base;
        logic [7:0] csum;

        vecs[0] = '{"idle_noise", 2, 64'h55_12, 0, 0, 1'b0, 1'b0};
        vecs[1] = '{"good3", 6, 64'hA5_03_11_22_33_69, 3, 1, 1'b0, 1'b0};
        vecs[2] = '{"bad_csum", 5, 64'hA5_02_10_20_00, 2, 0, 1'b1, 1'b1};
        vecs[3] = '{"a5_as_data", 4, 64'hA5_01_A5_A6, 1, 1, 1'b0, 1'b0};

        repeat (3) tick();
        reset = 1'b0;
        chk_reset_vals("reset");
        repeat (5) tick();

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Stop bit forced low inside a frame
        wr_base = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h3C, 1'b0);
        repeat (8) tick();
        chk("ferr_error", int'(error), 1);
        chk("ferr_busy", int'(busy), 0);
        chk("ferr_cpu_reset", int'(cpu_reset), 1);
        chk("ferr_writes", wr_cnt - wr_base, 0);
        v = '{"ferr_recover", 5, 64'hA5_02_10_20_32, 2, 1, 1'b0, 1'b0};
        run_vec(v);

        // 256-byte image: L = 0, data 0x00..0xFF, checksum 0x80
        wr_base = wr_cnt;
        done_base = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        csum = 8'h00;
        for (int k = 0; k < 256; k++) begin
            send_byte(8'(k), 1'b1);
            csum = csum + 8'(k);
        end
        send_byte(8'h80, 1'b1);
        repeat (8) tick();
        chk("full_csum_model", int'(csum), 8'h80);
        chk("full_writes", wr_cnt - wr_base, 256);
        for (int k = 0; k < 256; k++) begin
            if (wr_addr[(wr_base + k) % 1024] !== 8'(k) || wr_data[(wr_base + k) % 1024] !== 8'(k)) begin
                chk("full_write_k", int'(wr_addr[(wr_base + k) % 1024]), k);
            end
        end
        chk("full_last_addr", int'(mem_addr), 8'hFF);
        chk("full_done", done_cnt - done_base, 1);
        chk("full_cpu_reset", int'(cpu_reset), 0);
        chk("full_error", int'(error), 0);

        // One-cycle rx glitch mid-frame must not produce a byte
        wr_base = wr_cnt;
        done_base = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        repeat (6) tick();
        chk("glitch_busy_before", int'(busy), 1);
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (60) tick();
        chk("glitch_writes", wr_cnt - wr_base, 1);
        chk("glitch_busy_after", int'(busy), 1);
        chk("glitch_error", int'(error), 0);
        send_byte(8'h22, 1'b1);
        send_byte(8'h35, 1'b1);
        repeat (8) tick();
        chk("glitch_total_writes", wr_cnt - wr_base, 2);
        chk("glitch_data1", int'(wr_data[(wr_base + 1) % 1024]), 8'h22);
        chk("glitch_done", done_cnt - done_base, 1);
        chk("glitch_cpu_reset", int'(cpu_reset), 0);

        // Reset during DATA
        wr_base = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        repeat (6) tick();
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_cpu_reset", int'(cpu_reset), 1);
        chk("midrst_writes", wr_cnt - wr_base, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("midrst_after");
        repeat (10) tick();
        v = '{"post_reset", 6, 64'hA5_03_44_55_66_02, 3, 1, 1'b0, 1'b0};
        run_vec(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that sits directly upstream of the CPU instruction memory. It receives a framed program image over an 8N1 UART line and writes it byte-by-byte into a 256x8 program RAM write port. It holds the CPU in reset while a load is in progress and releases it only after the image checksum verifies. Without a load, the CPU runs whatever image the program memory already holds.

## Interface

- CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); must be >= 4
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock domain
- rx  in  1  asynchronous UART receive line, idle high
- cpu_reset  out  1  high holds the CPU in reset
- mem_we  out  1  program RAM write strobe, one cycle per byte
- mem_addr  out  8  program RAM write address
- mem_wdata  out  8  program RAM write data
- busy  out  1  high while a frame is in progress (states LEN, DATA, CSUM)
- done  out  1  one-cycle pulse on successful load
- error  out  1  sticky load-failure flag

## Operation

- Frame format: sync byte 0xA5, length byte L, N data bytes, checksum byte C.
  - N = L, except L = 0x00 means N = 256.
  - C must equal (L + sum of data bytes) mod 256.
- Data byte k (0-based) is written to mem_addr = k.
- RAM contents are overwritten as bytes arrive, before the checksum is known; a failed load leaves a partial image, and cpu_reset stays high.
- UART receiver:
  - rx passes through a 2-flop synchronizer.
  - Start is a falling edge on the synchronized line while the receiver is idle.
  - Start bit is re-sampled at CLKS_PER_BIT/2 (integer division); if high there, treat as a glitch and return to idle.
  - Data bits are sampled LSB first, every CLKS_PER_BIT cycles after the start mid-sample; stop bit is sampled one bit-time after data bit 7.
  - Stop = 1: internal byte_valid pulses for one cycle with the byte.
  - Stop = 0: internal frame_err pulses for one cycle and the byte is discarded.
  - After the stop sample the receiver returns to idle immediately and can detect the next start edge.
- Loader FSM states: IDLE, LEN, DATA, CSUM.
  - IDLE: on byte_valid with 0xA5, go to LEN. Other bytes and frame_err are ignored.
  - LEN: on byte_valid, latch L, clear the running sum to L, clear the address counter, then go to DATA.
  - DATA: on each byte_valid, write the byte, add it to the sum mod 256, and increment the address. After the Nth byte, go to CSUM. The address counter is 9 bits internally, so N = 256 is detected correctly; mem_addr is its low 8 bits.
  - CSUM: on byte_valid, go to IDLE. If C matches the sum, pulse done and clear error. Otherwise set error.
  - frame_err in LEN, DATA or CSUM: set error and go to IDLE.
- cpu_reset behaviour:
  - Rises on sync acceptance.
  - Falls only on checksum match.
  - Stays high after an error until a later load succeeds.
- A new 0xA5 seen in IDLE while error = 1 starts a new load. error remains set until that load's checksum matches.
- An 0xA5 byte inside a frame is treated as ordinary data; there is no resync mid-frame.

## Timing

- Reset values: cpu_reset 0, mem_we 0, mem_addr 0x00, mem_wdata 0x00, busy 0, done 0, error 0, FSM IDLE, receiver idle.
- Reset asserted mid-frame aborts the frame immediately. cpu_reset returns to 0 on the next cycle, so a partial image may execute; the system must reload.
- byte_valid and frame_err are registered in the cycle after the stop-bit sample.
- mem_we, mem_addr and mem_wdata are registered one cycle after byte_valid. mem_we is high for exactly one cycle; mem_addr and mem_wdata hold until the next write.
- cpu_reset rises in the cycle after the sync byte's byte_valid.
- done and the falling edge of cpu_reset occur in the same cycle, one cycle after the checksum's byte_valid.
- busy rises together with cpu_reset and falls in the cycle the FSM enters IDLE.
- Bytes sent back-to-back with a one-bit stop and no idle gap must all be received.

## Test plan

- CLKS_PER_BIT=4. Send A5 03 11 22 33 69 -> writes 0x11@0, 0x22@1, 0x33@2; done pulses once; cpu_reset goes 0; error stays 0.
- Send A5 02 10 20 00 (correct C = 0x32) -> two writes; error = 1; cpu_reset stays 1; no done pulse.
- Send A5 00, then data bytes 0x00..0xFF, then checksum 0x80 -> 256 writes to addresses 0x00..0xFF; done pulses.
- Send 0x55 0x12 while idle -> no writes; cpu_reset 0; busy 0.
- Send A5 02 then a byte with stop bit forced low -> error = 1; FSM returns to IDLE. A following good frame clears error and pulses done.
- Assert reset for one cycle during the DATA phase -> all outputs reach their reset values the next cycle. A subsequent full frame loads correctly.
- Drive a 1-cycle low glitch on rx -> no byte_valid and no state change.
